// File: rtl/ppm_symbol_decoder.sv
// rtl/ppm_symbol_decoder.sv - PPM frame decoder: marker-relative pulse timing to symbol (optional PPM_DEC_STATS_EN error counter)
module ppm_symbol_decoder #(
  parameter int SYM_BITS  = 4,
  parameter int SLOT_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                ppm_in,
  output logic [SYM_BITS-1:0] sym_out,
  output logic                sym_valid,
  output logic                sym_err,
  output logic                busy,
  output logic [7:0]          err_cnt
);

  localparam int NSLOTS    = 1 << SYM_BITS;
  localparam int SLOT      = 1 << SLOT_LOG2;
  localparam int FRAME_LEN = (NSLOTS + 1) * SLOT;
  localparam int T_W       = SYM_BITS + SLOT_LOG2 + 1;

  localparam logic [T_W-1:0] SLOT_T    = T_W'(SLOT);
  localparam logic [T_W-1:0] FRAME_END = T_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t              state, state_d;
  logic                sync1, sync2, hist;
  logic                rise;
  logic [T_W-1:0]      t, t_d;
  logic [T_W-1:0]      t_off;
  logic                have_data, have_data_d;
  logic                bad, bad_d;
  logic [SYM_BITS-1:0] slot, slot_d;
  logic [SYM_BITS-1:0] sym_d;
  logic                valid_d, err_d;

  // Two-flop synchroniser plus history flop; keeps running regardless of ena.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= ppm_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

  // Next-state and datapath: marker detection, slot capture, frame-end verdict.
  always_comb begin
    state_d     = state;
    t_d         = t;
    have_data_d = have_data;
    bad_d       = bad;
    slot_d      = slot;
    sym_d       = sym_out;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    t_off       = t - SLOT_T;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_d     = MEASURE;
            t_d         = T_W'(1);
            have_data_d = 1'b0;
            bad_d       = 1'b0;
          end
        end
        MEASURE: begin
          t_d = t + T_W'(1);
          if (rise) begin
            if (t < SLOT_T) begin
              bad_d = 1'b1;
            end else if (have_data) begin
              bad_d = 1'b1;
            end else begin
              slot_d      = t_off[SLOT_LOG2 +: SYM_BITS];
              have_data_d = 1'b1;
            end
          end
          // A rise landing on the last cycle is folded in before the verdict.
          if (t == FRAME_END) begin
            if (have_data_d && !bad_d) begin
              sym_d   = slot_d;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter, capture and output strobe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      t         <= '0;
      have_data <= 1'b0;
      bad       <= 1'b0;
      slot      <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      sym_err   <= 1'b0;
    end else begin
      state     <= state_d;
      t         <= t_d;
      have_data <= have_data_d;
      bad       <= bad_d;
      slot      <= slot_d;
      sym_out   <= sym_d;
      sym_valid <= valid_d;
      sym_err   <= err_d;
    end
  end

  assign busy = (state == MEASURE);

`ifdef PPM_DEC_STATS_EN
  logic [7:0] err_cnt_q;

  // Saturating count of rejected frames, updated on the same edge as the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
